// File: rtl/morse_round_controller.sv
// morse_round_controller: sequences one round of the Morse typing game.
// A target word is loaded (streamed from the pattern source in solo mode, typed by player 1
// in multiplayer mode), a guess is typed on the PS/2 keyboard, and the two symbol buffers are
// compared symbol by symbol.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mode, start           round mode (1 = solo) and start pulse, accepted only in IDLE
//   key_code, key_valid   PS/2 scancode byte and its strobe
//   tgt_sym/valid/ready   solo-mode target symbol handshake
//   busy, player          round in progress; 0 = target entry, 1 = guess entry
//   sym_count             fill level of the buffer currently being written
//   result_valid          one-cycle pulse on entry to RESULT
//   correct, wrong        round outcome, held until the next accepted start
//   overflow              sticky: a letter or target symbol was dropped
// Symbols: dot = 00, dash = 01, sp = 10, done = 11.
module morse_round_controller #(
    parameter int unsigned MAX_SYMS      = 32,
    parameter int unsigned RESULT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       start,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    input  logic [1:0] tgt_sym,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    output logic       busy,
    output logic       player,
    output logic [5:0] sym_count,
    output logic       result_valid,
    output logic       correct,
    output logic       wrong,
    output logic       overflow
);

    localparam int unsigned IdxW    = (MAX_SYMS > 1) ? $clog2(MAX_SYMS) : 1;
    localparam int unsigned ResW    = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
    localparam logic [5:0]  LastIdx = 6'(MAX_SYMS - 1);
    localparam logic [1:0]  SymSp   = 2'b10;
    localparam logic [1:0]  SymDone = 2'b11;

    typedef enum logic [2:0] {StIdle, StLoadTgt, StType, StCompare, StResult} state_e;

    state_e          state_q, state_d;
    logic            mode_q, mode_d, player_q, player_d;
    logic [5:0]      tgt_cnt_q, tgt_cnt_d, gss_cnt_q, gss_cnt_d;
    logic            skip_q, skip_d, closed_q, closed_d;
    logic [2:0]      exp_left_q, exp_left_d;
    logic [3:0]      exp_pat_q, exp_pat_d;
    logic            exp_enter_q, exp_enter_d;
    logic [IdxW-1:0] cmp_idx_q, cmp_idx_d;
    logic [ResW-1:0] res_cnt_q, res_cnt_d;
    logic            correct_q, correct_d, wrong_q, wrong_d;
    logic            overflow_q, overflow_d, result_valid_q, result_valid_d;
    logic [1:0]      tgt_buf_q [MAX_SYMS];
    logic [1:0]      tgt_buf_d [MAX_SYMS];
    logic [1:0]      gss_buf_q [MAX_SYMS];
    logic [1:0]      gss_buf_d [MAX_SYMS];

    logic       exp_busy, kb_en, wr_en, fits, cmp_ne, cmp_both_done;
    logic [1:0] wr_sym, cmp_t, cmp_g;
    logic [5:0] cur_cnt;
    logic [7:0] lut;

    // {hit, Morse length, pattern left-aligned with 1 = dash}
    function automatic logic [7:0] letter_lut(input logic [7:0] code);
        logic [7:0] r;
        case (code)
            8'h1C: r = {1'b1, 3'd2, 4'b0100}; // A
            8'h32: r = {1'b1, 3'd4, 4'b1000}; // B
            8'h21: r = {1'b1, 3'd4, 4'b1010}; // C
            8'h23: r = {1'b1, 3'd3, 4'b1000}; // D
            8'h24: r = {1'b1, 3'd1, 4'b0000}; // E
            8'h2B: r = {1'b1, 3'd4, 4'b0010}; // F
            8'h34: r = {1'b1, 3'd3, 4'b1100}; // G
            8'h33: r = {1'b1, 3'd4, 4'b0000}; // H
            8'h43: r = {1'b1, 3'd2, 4'b0000}; // I
            8'h3B: r = {1'b1, 3'd4, 4'b0111}; // J
            8'h42: r = {1'b1, 3'd3, 4'b1010}; // K
            8'h4B: r = {1'b1, 3'd4, 4'b0100}; // L
            8'h3A: r = {1'b1, 3'd2, 4'b1100}; // M
            8'h31: r = {1'b1, 3'd2, 4'b1000}; // N
            8'h44: r = {1'b1, 3'd3, 4'b1110}; // O
            8'h4D: r = {1'b1, 3'd4, 4'b0110}; // P
            8'h15: r = {1'b1, 3'd4, 4'b1101}; // Q
            8'h2D: r = {1'b1, 3'd3, 4'b0100}; // R
            8'h1B: r = {1'b1, 3'd3, 4'b0000}; // S
            8'h2C: r = {1'b1, 3'd1, 4'b1000}; // T
            8'h3C: r = {1'b1, 3'd3, 4'b0010}; // U
            8'h2A: r = {1'b1, 3'd4, 4'b0001}; // V
            8'h1D: r = {1'b1, 3'd3, 4'b0110}; // W
            8'h22: r = {1'b1, 3'd4, 4'b1001}; // X
            8'h35: r = {1'b1, 3'd4, 4'b1011}; // Y
            8'h1A: r = {1'b1, 3'd4, 4'b1100}; // Z
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    assign lut           = letter_lut(key_code);
    assign exp_busy      = (exp_left_q != 3'd0) || exp_enter_q;
    assign kb_en         = !closed_q && ((state_q == StType) || (state_q == StLoadTgt && !mode_q));
    assign cur_cnt       = player_q ? gss_cnt_q : tgt_cnt_q;
    // Letter plus trailing sp must leave the last slot free for done.
    assign fits          = (7'(cur_cnt) + 7'(lut[6:4]) + 7'd1) <= 7'(MAX_SYMS - 1);
    assign cmp_t         = tgt_buf_q[cmp_idx_q];
    assign cmp_g         = gss_buf_q[cmp_idx_q];
    assign cmp_ne        = cmp_t != cmp_g;
    assign cmp_both_done = (cmp_t == SymDone) && (cmp_g == SymDone);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic; closed_q holds one cycle so the finished buffer's count is visible.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StLoadTgt;
            StLoadTgt: if (closed_q) state_d = StType;
            StType:    if (closed_q) state_d = StCompare;
            StCompare: if (cmp_ne || cmp_both_done) state_d = StResult;
            StResult:  if (res_cnt_q == ResW'(RESULT_CYCLES - 1)) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy         = state_q != StIdle;
        tgt_ready    = (state_q == StLoadTgt) && mode_q && !closed_q && (tgt_cnt_q != LastIdx);
        player       = player_q;
        sym_count    = cur_cnt;
        result_valid = result_valid_q;
        correct      = correct_q;
        wrong        = wrong_q;
        overflow     = overflow_q;
    end

    // Datapath next-state
    always_comb begin
        mode_d         = mode_q;
        player_d       = player_q;
        tgt_cnt_d      = tgt_cnt_q;
        gss_cnt_d      = gss_cnt_q;
        skip_d         = skip_q;
        closed_d       = closed_q;
        exp_left_d     = exp_left_q;
        exp_pat_d      = exp_pat_q;
        exp_enter_d    = exp_enter_q;
        cmp_idx_d      = cmp_idx_q;
        res_cnt_d      = res_cnt_q;
        correct_d      = correct_q;
        wrong_d        = wrong_q;
        overflow_d     = overflow_q;
        result_valid_d = 1'b0;
        tgt_buf_d      = tgt_buf_q;
        gss_buf_d      = gss_buf_q;
        wr_en          = 1'b0;
        wr_sym         = SymSp;
        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d      = mode;
                    player_d    = 1'b0;
                    tgt_cnt_d   = '0;
                    gss_cnt_d   = '0;
                    skip_d      = 1'b0;
                    closed_d    = 1'b0;
                    exp_left_d  = '0;
                    exp_enter_d = 1'b0;
                    correct_d   = 1'b0;
                    wrong_d     = 1'b0;
                    overflow_d  = 1'b0;
                end
            end
            StLoadTgt, StType: begin
                if (exp_enter_q) begin
                    wr_en       = 1'b1;
                    wr_sym      = SymDone;
                    exp_enter_d = 1'b0;
                end else if (exp_left_q != 3'd0) begin
                    wr_en      = 1'b1;
                    wr_sym     = (exp_left_q == 3'd1) ? SymSp : {1'b0, exp_pat_q[3]};
                    exp_left_d = exp_left_q - 3'd1;
                    exp_pat_d  = {exp_pat_q[2:0], 1'b0};
                end else if (state_q == StLoadTgt && mode_q && !closed_q) begin
                    if (tgt_cnt_q == LastIdx) begin
                        // Source never sent done: terminate the word ourselves.
                        wr_en      = 1'b1;
                        wr_sym     = SymDone;
                        overflow_d = 1'b1;
                    end else if (tgt_valid && tgt_ready) begin
                        wr_en  = 1'b1;
                        wr_sym = tgt_sym;
                    end
                end
                if (wr_en) begin
                    if (player_q) begin
                        gss_buf_d[gss_cnt_q[IdxW-1:0]] = wr_sym;
                        gss_cnt_d = gss_cnt_q + 6'd1;
                    end else begin
                        tgt_buf_d[tgt_cnt_q[IdxW-1:0]] = wr_sym;
                        tgt_cnt_d = tgt_cnt_q + 6'd1;
                    end
                    if (wr_sym == SymDone) closed_d = 1'b1;
                end
                if (kb_en && key_valid) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else if (key_code == 8'hF0) begin
                        skip_d = 1'b1;
                    end else if (!exp_busy) begin
                        if (key_code == 8'h5A) begin
                            exp_enter_d = 1'b1;
                        end else if (lut[7]) begin
                            if (fits) begin
                                exp_left_d = lut[6:4] + 3'd1;
                                exp_pat_d  = lut[3:0];
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                    end
                end
                if (closed_q) begin
                    closed_d = 1'b0;
                    if (state_q == StLoadTgt) player_d  = 1'b1;
                    else                      cmp_idx_d = '0;
                end
            end
            StCompare: begin
                if (cmp_ne) begin
                    wrong_d        = 1'b1;
                    result_valid_d = 1'b1;
                    res_cnt_d      = '0;
                end else if (cmp_both_done) begin
                    correct_d      = 1'b1;
                    result_valid_d = 1'b1;
                    res_cnt_d      = '0;
                end else begin
                    cmp_idx_d = cmp_idx_q + IdxW'(1);
                end
            end
            StResult: res_cnt_d = res_cnt_q + ResW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q         <= 1'b0;
            player_q       <= 1'b0;
            tgt_cnt_q      <= '0;
            gss_cnt_q      <= '0;
            skip_q         <= 1'b0;
            closed_q       <= 1'b0;
            exp_left_q     <= '0;
            exp_pat_q      <= '0;
            exp_enter_q    <= 1'b0;
            cmp_idx_q      <= '0;
            res_cnt_q      <= '0;
            correct_q      <= 1'b0;
            wrong_q        <= 1'b0;
            overflow_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            player_q       <= player_d;
            tgt_cnt_q      <= tgt_cnt_d;
            gss_cnt_q      <= gss_cnt_d;
            skip_q         <= skip_d;
            closed_q       <= closed_d;
            exp_left_q     <= exp_left_d;
            exp_pat_q      <= exp_pat_d;
            exp_enter_q    <= exp_enter_d;
            cmp_idx_q      <= cmp_idx_d;
            res_cnt_q      <= res_cnt_d;
            correct_q      <= correct_d;
            wrong_q        <= wrong_d;
            overflow_q     <= overflow_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Buffer contents beyond the counts are don't-care, so no reset is needed.
    always_ff @(posedge clk) begin
        tgt_buf_q <= tgt_buf_d;
        gss_buf_q <= gss_buf_d;
    end

endmodule
